// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state type and width helpers for the reset sequencer
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// rtl/reset_sequencer_timer.sv - saturating cycle counter with a runtime terminal count
module rst_seq_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] tc,
    output logic          done
);

    logic [CW-1:0] cnt;

    assign done = (cnt == tc);

    // Stops at tc so the sequencer can wait on an acknowledge with done held high.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (enable && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered active-low reset release; RESET_SEQUENCER_ACK_EN adds ACK_I handshake
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int OUTPUTS     = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic               REQ_I,
`ifdef RESET_SEQUENCER_ACK_EN
    input  logic [OUTPUTS-1:0] ACK_I,
`endif
    output logic [OUTPUTS-1:0] NRST_O,
    output logic               BUSY_O,
    output logic               DONE_O
);

    localparam int CW = clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int IW = clog2(OUTPUTS + 1);
    localparam logic [CW-1:0] HOLD_TC  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_TC   = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(OUTPUTS - 1);
    localparam logic [IW-1:0] ALL_IDX  = IW'(OUTPUTS);

    seq_state_t    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] tc;
    logic          restart;
    logic          tmr_done;
    logic          tmr_clear;
    logic          tmr_enable;
    logic          stage_ack;
    logic          last_ack;
    logic          fire;

`ifdef RESET_SEQUENCER_ACK_EN
    logic [OUTPUTS-1:0] ack_shifted;

    always_comb begin
        ack_shifted = '0;
        stage_ack   = 1'b1;
        if (idx != '0) begin
            ack_shifted = ACK_I >> (idx - 1'b1);
            stage_ack   = ack_shifted[0];
        end
        last_ack = ACK_I[OUTPUTS-1];
    end
`else
    assign stage_ack = 1'b1;
    assign last_ack  = 1'b1;
`endif

    assign restart    = RST_I || REQ_I;
    assign fire       = tmr_done && ((state == ASSERT) ||
                        ((state == RELEASE) && (idx != ALL_IDX) && stage_ack));
    assign tmr_clear  = restart || fire;
    assign tmr_enable = (state == ASSERT) || (state == RELEASE);
    assign tc         = (state == ASSERT) ? HOLD_TC : GAP_TC;

    rst_seq_timer #(
        .CW(CW)
    ) u_timer (
        .clk   (CLK_I),
        .clear (tmr_clear),
        .enable(tmr_enable),
        .tc    (tc),
        .done  (tmr_done)
    );

    always_ff @(posedge CLK_I) begin
        if (restart) begin
            state  <= ASSERT;
            idx    <= '0;
            NRST_O <= '0;
            BUSY_O <= 1'b1;
            DONE_O <= 1'b0;
        end else begin
            DONE_O <= 1'b0;
            case (state)
                ASSERT: begin
                    if (tmr_done) begin
                        NRST_O[0] <= 1'b1;
                        idx       <= IW'(1);
                        if ((OUTPUTS == 1) && last_ack) begin
                            state  <= RUN;
                            BUSY_O <= 1'b0;
                            DONE_O <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    // idx == ALL_IDX only when every stage is out but the last ack is pending.
                    if (idx == ALL_IDX) begin
                        if (last_ack) begin
                            state  <= RUN;
                            BUSY_O <= 1'b0;
                            DONE_O <= 1'b1;
                        end
                    end else if (tmr_done && stage_ack) begin
                        NRST_O <= NRST_O | (OUTPUTS'(1) << idx);
                        idx    <= idx + 1'b1;
                        if ((idx == LAST_IDX) && last_ack) begin
                            state  <= RUN;
                            BUSY_O <= 1'b0;
                            DONE_O <= 1'b1;
                        end
                    end
                end
                RUN: begin
                end
                default: begin
                    state  <= ASSERT;
                    idx    <= '0;
                    NRST_O <= '0;
                    BUSY_O <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed vector bench for reset_sequencer (OUTPUTS=3, HOLD=4, GAP=2)
module tb_reset_sequencer;

    localparam int OUTPUTS = 3;

    typedef struct {
        logic                rst;
        logic                req;
        logic [OUTPUTS-1:0]  nrst;
        logic                busy;
        logic                done;
    } vec_t;

    logic               clk;
    logic               rst;
    logic               req;
    logic [OUTPUTS-1:0] ack;
    logic [OUTPUTS-1:0] nrst;
    logic               busy;
    logic               done;

    int compared;
    int mismatched;
    vec_t vecs[$];

    reset_sequencer #(
        .OUTPUTS    (OUTPUTS),
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2)
    ) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .REQ_I (req),
`ifdef RESET_SEQUENCER_ACK_EN
        .ACK_I (ack),
`endif
        .NRST_O(nrst),
        .BUSY_O(busy),
        .DONE_O(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic q, input logic [OUTPUTS-1:0] n,
                       input logic b, input logic d);
        vec_t v;
        v.rst = r; v.req = q; v.nrst = n; v.busy = b; v.done = d;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [OUTPUTS-1:0] n,
                         input logic b, input logic d);
        compared = compared + 1;
        if (nrst !== n || busy !== b || done !== d) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got nrst=%b busy=%b done=%b, want nrst=%b busy=%b done=%b",
                     name, nrst, busy, done, n, b, d);
        end
    endtask

    initial begin
        int cycles;
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        req = 1'b0;
        ack = '1;

        // 1: reset held three edges, then release at t+4/t+6/t+8
        repeat (3) add(1, 0, 3'b000, 1, 0);
        repeat (3) add(0, 0, 3'b000, 1, 0);
        add(0, 0, 3'b001, 1, 0); add(0, 0, 3'b001, 1, 0);
        add(0, 0, 3'b011, 1, 0); add(0, 0, 3'b011, 1, 0);
        add(0, 0, 3'b111, 0, 1);
        add(0, 0, 3'b111, 0, 0); add(0, 0, 3'b111, 0, 0);
        // 2: single request from RUN
        add(0, 1, 3'b000, 1, 0);
        repeat (3) add(0, 0, 3'b000, 1, 0);
        add(0, 0, 3'b001, 1, 0); add(0, 0, 3'b001, 1, 0);
        add(0, 0, 3'b011, 1, 0); add(0, 0, 3'b011, 1, 0);
        add(0, 0, 3'b111, 0, 1); add(0, 0, 3'b111, 0, 0);
        // 3: second request after stage 0 is out restarts the full hold
        add(0, 1, 3'b000, 1, 0);
        repeat (3) add(0, 0, 3'b000, 1, 0);
        add(0, 0, 3'b001, 1, 0);
        add(0, 1, 3'b000, 1, 0);
        repeat (3) add(0, 0, 3'b000, 1, 0);
        add(0, 0, 3'b001, 1, 0); add(0, 0, 3'b001, 1, 0);
        add(0, 0, 3'b011, 1, 0); add(0, 0, 3'b011, 1, 0);
        add(0, 0, 3'b111, 0, 1); add(0, 0, 3'b111, 0, 0);
        // 4: reset together with request while two stages are out
        add(0, 1, 3'b000, 1, 0);
        repeat (3) add(0, 0, 3'b000, 1, 0);
        add(0, 0, 3'b001, 1, 0); add(0, 0, 3'b001, 1, 0);
        add(0, 0, 3'b011, 1, 0);
        add(1, 1, 3'b000, 1, 0);
        repeat (3) add(0, 0, 3'b000, 1, 0);
        add(0, 0, 3'b001, 1, 0); add(0, 0, 3'b001, 1, 0);
        add(0, 0, 3'b011, 1, 0); add(0, 0, 3'b011, 1, 0);
        add(0, 0, 3'b111, 0, 1); add(0, 0, 3'b111, 0, 0);
        // 5: request held for ten edges pins the counter
        repeat (10) add(0, 1, 3'b000, 1, 0);
        repeat (3) add(0, 0, 3'b000, 1, 0);
        add(0, 0, 3'b001, 1, 0); add(0, 0, 3'b001, 1, 0);
        add(0, 0, 3'b011, 1, 0); add(0, 0, 3'b011, 1, 0);
        add(0, 0, 3'b111, 0, 1); add(0, 0, 3'b111, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req);
            check($sformatf("vec%0d", i), vecs[i].nrst, vecs[i].busy, vecs[i].done);
        end

        // Request to DONE latency measured with a bounded wait
        step(0, 1);
        cycles = 0;
        rst = 1'b0;
        req = 1'b0;
        while (done !== 1'b1 && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles = cycles + 1;
        end
        compared = compared + 1;
        if (cycles != 8) begin
            mismatched = mismatched + 1;
            $display("FAIL done_latency: got %0d cycles, want 8", cycles);
        end
        check("done_state", 3'b111, 0, 1);
        step(0, 0);
        check("done_drop", 3'b111, 0, 0);

`ifdef RESET_SEQUENCER_ACK_EN
        // 6: stall on missing acknowledges
        ack = '0;
        step(1, 0);
        check("ack_rst", 3'b000, 1, 0);
        for (int k = 1; k <= 20; k++) begin
            step(0, 0);
            if (k < 4) check($sformatf("ack_hold%0d", k), 3'b000, 1, 0);
            else       check($sformatf("ack_stall%0d", k), 3'b001, 1, 0);
        end
        ack = 3'b001;
        step(0, 0);
        check("ack_stage1", 3'b011, 1, 0);
        ack = 3'b111;
        step(0, 0);
        check("ack_gap", 3'b011, 1, 0);
        step(0, 0);
        check("ack_stage2", 3'b111, 0, 1);
        step(0, 0);
        check("ack_run", 3'b111, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
